// File: rtl/scan_pkg.sv
// Shared types and default widths for the scan engine and its step dividers.
package scan_pkg;

   localparam int unsigned COORD_W_DEF = 16;
   localparam int unsigned DWELL_W_DEF = 32;

   typedef enum logic [1:0] {
      MODE_RASTER = 2'd0,
      MODE_SERP   = 2'd1,
      MODE_COLUMN = 2'd2
   } scan_mode_t;

   typedef enum logic [2:0] {
      IDLE,
      CALC,
      LOAD,
      SEND,
      DWELL,
      DONE
   } scan_state_t;

   // Mode code 3 is reserved and runs as raster.
   function automatic scan_mode_t decode_mode(input logic [1:0] m);
      case (m)
         2'd1:    return MODE_SERP;
         2'd2:    return MODE_COLUMN;
         default: return MODE_RASTER;
      endcase
   endfunction

endpackage

// File: rtl/scan_engine_if.sv
// Point bus towards the XY2-100 transmitter: coordinate pair, send strobe, back-pressure.
interface scan_engine_if #(
   parameter int unsigned COORD_W = 16
);
   logic [COORD_W-1:0] x_coord;
   logic [COORD_W-1:0] y_coord;
   logic               xy2_send;
   logic               tx_ready;

   modport master (output x_coord, output y_coord, output xy2_send, input tx_ready);
   modport slave  (input x_coord, input y_coord, input xy2_send, output tx_ready);
endinterface

// File: rtl/scan_step_div.sv
// Restoring unsigned divider: W iterations after start, done flags the last one; x/0 yields 0.
module scan_step_div #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] quotient,
   output logic         done
);
   localparam int unsigned CNT_W = $clog2(W + 1);

   logic [W-1:0]     rem;
   logic [W-1:0]     dvs;
   logic [CNT_W-1:0] cnt;
   logic [W:0]       shifted;

   assign shifted = {rem, quotient[W-1]};

   // quotient doubles as the dividend shift register; it stays 0 when dividing by zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         rem      <= '0;
         dvs      <= '0;
         cnt      <= '0;
         quotient <= '0;
         done     <= 1'b0;
      end else if (start) begin
         rem      <= '0;
         dvs      <= divisor;
         quotient <= (divisor == '0) ? '0 : dividend;
         cnt      <= CNT_W'(W);
         done     <= (W == 1);
      end else if (cnt != '0) begin
         cnt  <= cnt - CNT_W'(1);
         done <= (cnt == CNT_W'(2));
         if (dvs != '0) begin
            if (shifted >= {1'b0, dvs}) begin
               rem      <= W'(shifted - {1'b0, dvs});
               quotient <= {quotient[W-2:0], 1'b1};
            end else begin
               rem      <= shifted[W-1:0];
               quotient <= {quotient[W-2:0], 1'b0};
            end
         end
      end else begin
         done <= 1'b0;
      end
   end

endmodule

// File: rtl/scan_engine.sv
// Run-time selectable raster/serpentine/column scan generator feeding the XY2-100 transmitter.
// Define SCAN_CONTINUOUS_EN to repeat the latched frame until abort.
module scan_engine
   import scan_pkg::*;
#(
   parameter int unsigned COORD_W = COORD_W_DEF,
   parameter int unsigned DWELL_W = DWELL_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [1:0]         mode,
   input  logic [COORD_W-1:0] nx_pix,
   input  logic [COORD_W-1:0] ny_pix,
   input  logic [COORD_W-1:0] nx_min,
   input  logic [COORD_W-1:0] nx_max,
   input  logic [COORD_W-1:0] ny_min,
   input  logic [COORD_W-1:0] ny_max,
   input  logic [DWELL_W-1:0] dwell,
   scan_engine_if.master      xy,
   output logic               busy,
   output logic               frame_done,
   output logic               cfg_err
);

   scan_state_t        state, state_next;
   scan_mode_t         mode_q;
   logic [COORD_W-1:0] nx_q, ny_q, xmin_q, ymin_q;
   logic [COORD_W-1:0] x_q, y_q, fast_idx, slow_idx, fast_n, slow_n;
   logic [COORD_W-1:0] dvd_x, dvd_y, dvs_x, dvs_y, step_x, step_y;
   logic [DWELL_W-1:0] dwell_rl, dwell_cnt;
   logic               dir_q, done_x, done_y, calc_done, accept;
   logic               empty, line_end, last_pt, send_c;

   // Inverted bounds give a zero span; fewer than two points give a zero divisor.
   assign dvd_x = (nx_max < nx_min) ? '0 : nx_max - nx_min;
   assign dvd_y = (ny_max < ny_min) ? '0 : ny_max - ny_min;
   assign dvs_x = (nx_pix < COORD_W'(2)) ? '0 : nx_pix - COORD_W'(1);
   assign dvs_y = (ny_pix < COORD_W'(2)) ? '0 : ny_pix - COORD_W'(1);

   scan_step_div #(.W(COORD_W)) u_div_x (
      .clk(clk), .reset(reset), .start(accept),
      .dividend(dvd_x), .divisor(dvs_x), .quotient(step_x), .done(done_x)
   );

   scan_step_div #(.W(COORD_W)) u_div_y (
      .clk(clk), .reset(reset), .start(accept),
      .dividend(dvd_y), .divisor(dvs_y), .quotient(step_y), .done(done_y)
   );

   assign calc_done = done_x & done_y;
   assign accept    = (state == IDLE) && (state_next == CALC);
   assign empty     = (nx_q == '0) || (ny_q == '0);
   assign fast_n    = (mode_q == MODE_COLUMN) ? ny_q : nx_q;
   assign slow_n    = (mode_q == MODE_COLUMN) ? nx_q : ny_q;
   assign line_end  = (fast_idx == fast_n - COORD_W'(1));
   assign last_pt   = line_end && (slow_idx == slow_n - COORD_W'(1));

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      send_c     = 1'b0;
      if (abort) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:  if (start) state_next = CALC;
            CALC:  if (calc_done) state_next = empty ? DONE : LOAD;
            LOAD:  state_next = SEND;
            SEND:  if (xy.tx_ready) begin
                      send_c     = 1'b1;
                      state_next = DWELL;
                   end
            DWELL: if (dwell_cnt == '0) state_next = last_pt ? DONE : SEND;
`ifdef SCAN_CONTINUOUS_EN
            DONE:  state_next = empty ? IDLE : LOAD;
`else
            DONE:  state_next = IDLE;
`endif
            default: state_next = IDLE;
         endcase
      end
   end

   // Frame configuration is captured only on the accepted start.
   always_ff @(posedge clk) begin
      if (accept) begin
         mode_q   <= decode_mode(mode);
         nx_q     <= nx_pix;
         ny_q     <= ny_pix;
         xmin_q   <= nx_min;
         ymin_q   <= ny_min;
         dwell_rl <= (dwell < DWELL_W'(2)) ? '0 : dwell - DWELL_W'(2);
      end
   end

   // Accumulator walk: fast axis steps each point, slow axis steps at line end.
   always_ff @(posedge clk) begin
      if (reset) begin
         x_q       <= '0;
         y_q       <= '0;
         fast_idx  <= '0;
         slow_idx  <= '0;
         dir_q     <= 1'b0;
         dwell_cnt <= '0;
      end else if (state == LOAD && state_next == SEND) begin
         x_q      <= xmin_q;
         y_q      <= ymin_q;
         fast_idx <= '0;
         slow_idx <= '0;
         dir_q    <= 1'b0;
      end else if (state == SEND && state_next == DWELL) begin
         dwell_cnt <= dwell_rl;
      end else if (state == DWELL) begin
         if (dwell_cnt != '0) begin
            dwell_cnt <= dwell_cnt - DWELL_W'(1);
         end else if (state_next == SEND) begin
            if (line_end) begin
               fast_idx <= '0;
               slow_idx <= slow_idx + COORD_W'(1);
               dir_q    <= ~dir_q;
               if (mode_q == MODE_COLUMN) begin
                  x_q <= x_q + step_x;
                  y_q <= ymin_q;
               end else begin
                  y_q <= y_q + step_y;
                  if (mode_q == MODE_RASTER) x_q <= xmin_q;
               end
            end else begin
               fast_idx <= fast_idx + COORD_W'(1);
               if (mode_q == MODE_COLUMN)             y_q <= y_q + step_y;
               else if (mode_q == MODE_SERP && dir_q) x_q <= x_q - step_x;
               else                                   x_q <= x_q + step_x;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy       <= 1'b0;
         frame_done <= 1'b0;
         cfg_err    <= 1'b0;
      end else begin
         busy       <= (state_next != IDLE);
         frame_done <= (state_next == DONE);
         if (accept) cfg_err <= (nx_max < nx_min) || (ny_max < ny_min);
      end
   end

   assign xy.x_coord  = x_q;
   assign xy.y_coord  = y_q;
   assign xy.xy2_send = send_c;

endmodule

// File: doc/scan_engine.md
Name: scan_engine

Overview:
- Parametrised successor to the three fixed-pattern scan generators and their output mux; a single engine selects raster, serpentine or column pattern at run time.
- Computes per-axis step sizes in hardware from pixel count and min/max bounds, walks the grid, and holds each point for a programmable dwell time.
- Drives the XY2-100 transmitter with a coordinate pair plus a one-cycle send strobe, stalling on transmitter back-pressure.

Parameters:
- COORD_W, 16, width of coordinates, bounds and pixel counts.
- DWELL_W, 32, width of the dwell (pixel time) counter.

Ports:
- clk  in  1  system clock (50 MHz domain); all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a frame; sampled only in IDLE.
- abort  in  1  stop the current frame; return to IDLE.
- mode  in  2  0 raster (x fast, flyback), 1 serpentine (x fast, alternate lines reversed), 2 column (y fast, flyback), 3 reserved (treated as 0).
- nx_pix  in  COORD_W  points per x line.
- ny_pix  in  COORD_W  points per y line.
- nx_min  in  COORD_W  x lower bound.
- nx_max  in  COORD_W  x upper bound.
- ny_min  in  COORD_W  y lower bound.
- ny_max  in  COORD_W  y upper bound.
- dwell  in  DWELL_W  clk cycles per point.
- tx_ready  in  1  transmitter can accept a new point.
- x_coord  out  COORD_W  current x.
- y_coord  out  COORD_W  current y.
- xy2_send  out  1  one-cycle strobe; x_coord and y_coord are valid in that cycle.
- busy  out  1  high outside IDLE.
- frame_done  out  1  one-cycle pulse after the last point's dwell expires.
- cfg_err  out  1  sticky until next start; set when max < min on either axis.

Behaviour:
- Reset: state IDLE; x_coord=0, y_coord=0, xy2_send=0, busy=0, frame_done=0, cfg_err=0.
- Latching: all config inputs (mode, counts, bounds, dwell) are latched on the accepted start. Input changes mid-frame have no effect. start while busy is ignored.
- States:
  - IDLE -> CALC on start.
  - CALC: two parallel dividers compute step = (max-min)/(n-1), truncated. Takes exactly COORD_W cycles.
  - LOAD: first point; one cycle.
  - SEND: xy2_send=1 for one cycle, only when tx_ready=1; otherwise wait with xy2_send=0.
  - DWELL: hold the point.
  - DWELL to SEND with the next point, or to DONE after the last point.
  - DONE: frame_done pulse, then IDLE.
- Latency: with start accepted in cycle t and tx_ready=1, the first xy2_send occurs in cycle t+COORD_W+2.
- Point period: consecutive xy2_send pulses are exactly max(dwell,2) cycles apart while tx_ready stays high. A low tx_ready extends the period cycle-for-cycle. dwell=0 or 1 behaves as 2.
- Coordinate arithmetic: coord = min + idx*step, generated by an accumulator (no multiplier). The last point is min+(n-1)*step, which is ≤ max.
- Serpentine: odd-numbered lines start at min+(n-1)*step and decrement by step.
- Boundary conditions:
  - n=1 on an axis: step=0; that axis stays at min.
  - nx_pix=0 or ny_pix=0: no xy2_send; frame_done is pulsed in the cycle after CALC.
  - max<min on an axis: cfg_err=1, step forced to 0, that axis pinned to min; the frame still runs.
- abort: takes priority in any state. The next cycle is IDLE with xy2_send=0 and no frame_done; x_coord and y_coord hold their last values.
- Simultaneous events: abort and start in the same cycle in IDLE means abort wins and the start is dropped. reset overrides everything.

Optional Feature:
- SCAN_CONTINUOUS_EN defined: after the last point, return to LOAD and repeat the frame with the latched config until abort. frame_done pulses at the end of every frame; steps are not recomputed.
- Not defined: single frame, then IDLE.

Decomposition:
- Shared package scan_pkg:
  - scan_mode_t enum (MODE_RASTER, MODE_SERP, MODE_COLUMN).
  - scan_state_t enum (IDLE, CALC, LOAD, SEND, DWELL, DONE).
  - COORD_W_DEF=16 and DWELL_W_DEF=32.
- Sub-module scan_step_div: restoring unsigned divider, COORD_W cycles, start/done handshake, divide-by-zero returns 0. Instantiated twice (x and y).

Test Plan:
- Raster: mode=0, nx=3, ny=2, x 0..100, y 0..10, dwell=5, tx_ready=1 -> points (0,0)(50,0)(100,0)(0,10)(50,10)(100,10); sends 5 cycles apart; first send at start+18; one frame_done.
- Serpentine/column: mode=1 with the same config -> (0,0)(50,0)(100,0)(100,10)(50,10)(0,10). mode=2 -> (0,0)(0,10)(50,0)(50,10)(100,0)(100,10).
- Truncation/degenerate: nx=4, x 0..10, ny=1, y_min=7 -> x 0,3,6,9 with y=7. nx=0 -> zero sends and frame_done. x_max=5, x_min=9 -> cfg_err=1 and x stuck at 9.
- Back-pressure: tx_ready low for 20 cycles at the second point -> xy2_send held off; the point is sent on the first cycle tx_ready=1; the coordinate sequence is unchanged.
- Abort/restart: abort after the third send -> IDLE next cycle, no frame_done, coordinates held. A new start reproduces the full sequence from (x_min,y_min).
- Continuous (SCAN_CONTINUOUS_EN): 3x2 raster -> sequence repeats; a frame_done occurs every 6 sends; stops only on abort.
